// File: rtl/riscy_pkg.sv
// Shared riscy_core control definitions: ALU codes, opcodes, FSM state codes,
// datapath mux encodings and fault causes.
package riscy_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef logic [3:0] state_e;
    localparam state_e S_FETCH    = 4'd0;
    localparam state_e S_DECODE   = 4'd1;
    localparam state_e S_MEMADR   = 4'd2;
    localparam state_e S_MEMREAD  = 4'd3;
    localparam state_e S_MEMWB    = 4'd4;
    localparam state_e S_MEMWRITE = 4'd5;
    localparam state_e S_EXECR    = 4'd6;
    localparam state_e S_EXECI    = 4'd7;
    localparam state_e S_ALUWB    = 4'd8;
    localparam state_e S_BEQ      = 4'd9;
    localparam state_e S_JAL      = 4'd10;
    localparam state_e S_FAULT    = 4'd11;

    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RS1      = 2'b10;
    localparam logic [1:0] SRCB_RS2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_RESULT    = 1'b1;

    typedef enum logic [1:0] {
        FC_NONE        = 2'b00,
        FC_MEM_TIMEOUT = 2'b01,
        FC_ILLEGAL     = 2'b10
    } fault_cause_e;

    // States that hold a memory request open and run the wait counter.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multicycle controller (master) and the riscy_core
// datapath / memory port (slave).
interface multicycle_ctrl_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       z;
    logic       mem_ready;

    logic       mem_req;
    logic [2:0] alu_ctrl;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       fault;
    logic [1:0] fault_cause;

    modport master (
        input  op, funct3, funct7b5, z, mem_ready,
        output mem_req, alu_ctrl, alu_src_a, alu_src_b, result_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, fault, fault_cause
    );

    modport slave (
        output op, funct3, funct7b5, z, mem_ready,
        input  mem_req, alu_ctrl, alu_src_a, alu_src_b, result_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, fault, fault_cause
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from opcode/funct fields, flagging
// unknown opcodes and unsupported funct3 on R/I-type as illegal.
module alu_decoder
    import riscy_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_ctrl_e  alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (op)
            OP_RTYPE, OP_ITYPE: begin
                case (funct3)
                    // funct7b5 is part of the immediate on I-type, so only R-type subtracts
                    3'b000:  alu_ctrl = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: illegal  = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_JAL: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for riscy_core. Define ILLEGAL_TRAP_EN to trap illegal
// instructions into FAULT; otherwise they retire as NOPs.
module multicycle_ctrl
    import riscy_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_e         state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic           timeout;
    logic           fault_q;
    fault_cause_e   cause_q;
    alu_ctrl_e      dec_ctrl;
    logic           dec_illegal;

    alu_decoder u_alu_decoder (
        .op       (bus.op),
        .funct3   (bus.funct3),
        .funct7b5 (bus.funct7b5),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal)
    );

    // A ready in the expiry cycle completes normally, so timeout needs !mem_ready.
    assign timeout = (MEM_TIMEOUT > 0) && is_mem_state(state) && !bus.mem_ready &&
                     (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (timeout)            state_nxt = S_FAULT;
                else if (bus.mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECR;
                    OP_ITYPE:     state_nxt = S_EXECI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_nxt = S_FAULT;
`else
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (timeout)            state_nxt = S_FAULT;
                else if (bus.mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (timeout)            state_nxt = S_FAULT;
                else if (bus.mem_ready) state_nxt = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                if (!dec_illegal)       state_nxt = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
                else                    state_nxt = S_FAULT;
`else
                else                    state_nxt = S_FETCH;
`endif
            end
            S_MEMWB, S_ALUWB, S_BEQ: state_nxt = S_FETCH;
            S_JAL:   state_nxt = S_ALUWB;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
            cause_q  <= FC_NONE;
        end else begin
            state <= state_nxt;
            // Any state change re-arms the counter, covering every memory-state entry.
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (is_mem_state(state) && !bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (state_nxt == S_FAULT && state != S_FAULT) begin
                fault_q <= 1'b1;
                cause_q <= timeout ? FC_MEM_TIMEOUT : FC_ILLEGAL;
            end
        end
    end

    logic       mem_req_c, adr_c, ir_w_c, pc_w_c, reg_w_c, mem_w_c;
    alu_ctrl_e  alu_c;
    logic [1:0] src_a_c, src_b_c, res_c;

    always_comb begin
        mem_req_c = 1'b0;
        alu_c     = ALU_ADD;
        src_a_c   = SRCA_PC;
        src_b_c   = SRCB_RS2;
        res_c     = RES_ALUOUT;
        adr_c     = ADR_PC;
        ir_w_c    = 1'b0;
        pc_w_c    = 1'b0;
        reg_w_c   = 1'b0;
        mem_w_c   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                src_a_c   = SRCA_PC;
                src_b_c   = SRCB_FOUR;
                res_c     = RES_ALURESULT;
                ir_w_c    = bus.mem_ready;
                pc_w_c    = bus.mem_ready;
            end
            S_DECODE: begin
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
            end
            S_MEMADR: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_c     = ADR_RESULT;
            end
            S_MEMWB: begin
                res_c   = RES_MEMDATA;
                reg_w_c = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_c = 1'b1;
                adr_c     = ADR_RESULT;
                mem_w_c   = 1'b1;
            end
            S_EXECR: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_RS2;
                alu_c   = dec_ctrl;
            end
            S_EXECI: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_IMM;
                alu_c   = dec_ctrl;
            end
            S_ALUWB: reg_w_c = 1'b1;
            S_BEQ: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_RS2;
                alu_c   = ALU_SUB;
                pc_w_c  = bus.z;
            end
            // ALUout still holds the target from DECODE while the ALU forms oldPC+4 for rd.
            S_JAL: begin
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_FOUR;
                pc_w_c  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_req     = mem_req_c;
    assign bus.alu_ctrl    = alu_c;
    assign bus.alu_src_a   = src_a_c;
    assign bus.alu_src_b   = src_b_c;
    assign bus.result_src  = res_c;
    assign bus.adr_src     = adr_c;
    assign bus.ir_write    = ir_w_c  & ~rst;
    assign bus.pc_write    = pc_w_c  & ~rst;
    assign bus.reg_write   = reg_w_c & ~rst;
    assign bus.mem_write   = mem_w_c & ~rst;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words are
// queued as stimulus is driven and compared at the following falling edge.
module tb_multicycle_ctrl;

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_vec(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%05h exp=%05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] snap();
        return {bus.mem_req, bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b, bus.result_src,
                bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write,
                bus.fault, bus.fault_cause};
    endfunction

    function automatic logic [17:0] mk(input logic mreq, input logic [2:0] c,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic mw, input logic f, input logic [1:0] fc);
        return {mreq, c, a, b, res, adr, irw, pcw, rw, mw, f, fc};
    endfunction

    function automatic logic [17:0] ex_fetch(input logic rdy);
        return mk(1, 3'b000, 2'b00, 2'b10, 2'b10, 0, rdy, rdy, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_decode();
        return mk(0, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_memadr();
        return mk(0, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_memread();
        return mk(1, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_memwb();
        return mk(0, 3'b000, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_memwrite();
        return mk(1, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_exec(input logic [2:0] c, input logic imm);
        return mk(0, c, 2'b10, imm ? 2'b01 : 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_aluwb();
        return mk(0, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_beq(input logic zz);
        return mk(0, 3'b001, 2'b10, 2'b00, 2'b00, 0, 0, zz, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_jal();
        return mk(0, 3'b000, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00);
    endfunction
    function automatic logic [17:0] ex_fault(input logic [1:0] fc);
        return mk(0, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, fc);
    endfunction

    // Drive one cycle of inputs, queue its expectation, compare before the next rising edge.
    task automatic step(input string tag, input logic rdy, input logic zz, input logic [17:0] exp);
        exp_t e;
        bus.mem_ready = rdy;
        bus.z         = zz;
        sb.push_back('{tag: tag, v: exp});
        @(negedge clk);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_vec(e.tag, snap(), e.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
    endtask

    task automatic do_reset();
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_alu(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] c);
        set_ir(o, f3, f7);
        step({nm, "_fetch"}, 1, 0, ex_fetch(1));
        step({nm, "_decode"}, 1, 0, ex_decode());
        step({nm, "_exec"}, 1, 0, ex_exec(c, o == I_OP));
        step({nm, "_aluwb"}, 1, 0, ex_aluwb());
    endtask

    initial begin
        set_ir(7'b0, 3'b0, 1'b0);
        bus.z         = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        check_vec("reset_async", snap(), ex_fetch(0));
        @(posedge clk);
        #1;
        check_vec("reset_held", snap(), ex_fetch(0));
        rst = 1'b0;

        run_alu("add",  R_OP, 3'b000, 0, 3'b000);
        run_alu("sub",  R_OP, 3'b000, 1, 3'b001);
        run_alu("addi", I_OP, 3'b000, 1, 3'b000);
        run_alu("slti", I_OP, 3'b010, 0, 3'b101);
        run_alu("ori",  I_OP, 3'b110, 0, 3'b011);
        run_alu("andi", I_OP, 3'b111, 0, 3'b010);
        run_alu("or",   R_OP, 3'b110, 1, 3'b011);

        for (int zz = 1; zz >= 0; zz--) begin
            set_ir(7'b1100011, 3'b000, 0);
            step("beq_fetch", 1, logic'(zz), ex_fetch(1));
            step("beq_decode", 1, logic'(zz), ex_decode());
            step("beq_exec", 1, logic'(zz), ex_beq(logic'(zz)));
        end

        set_ir(7'b1101111, 3'b000, 0);
        step("jal_fetch", 1, 0, ex_fetch(1));
        step("jal_decode", 1, 0, ex_decode());
        step("jal_exec", 1, 0, ex_jal());
        step("jal_aluwb", 1, 0, ex_aluwb());

        // lw: three stall cycles, then ready lands in the timeout expiry cycle
        set_ir(7'b0000011, 3'b010, 0);
        step("lw_fetch", 1, 0, ex_fetch(1));
        step("lw_decode", 1, 0, ex_decode());
        step("lw_memadr", 1, 0, ex_memadr());
        for (int i = 0; i < 3; i++) step("lw_memread_wait", 0, 0, ex_memread());
        step("lw_memread_done", 1, 0, ex_memread());
        step("lw_memwb", 1, 0, ex_memwb());

        set_ir(7'b0100011, 3'b010, 0);
        step("sw_fetch", 1, 0, ex_fetch(1));
        step("sw_decode", 1, 0, ex_decode());
        step("sw_memadr", 1, 0, ex_memadr());
        for (int i = 0; i < 2; i++) step("sw_memwrite_wait", 0, 0, ex_memwrite());
        step("sw_memwrite_done", 1, 0, ex_memwrite());

        // fetch timeout
        set_ir(R_OP, 3'b000, 0);
        for (int i = 0; i < 4; i++) step("to_fetch_wait", 0, 0, ex_fetch(0));
        step("to_fault", 1, 0, ex_fault(2'b01));
        step("to_fault_sticky", 1, 0, ex_fault(2'b01));
        do_reset();
        for (int i = 0; i < 3; i++) step("nto_fetch_wait", 0, 0, ex_fetch(0));
        step("nto_fetch_done", 1, 0, ex_fetch(1));
        step("nto_decode", 1, 0, ex_decode());
        step("nto_exec", 1, 0, ex_exec(3'b000, 0));
        step("nto_aluwb", 1, 0, ex_aluwb());

        // asynchronous reset in the middle of a store
        set_ir(7'b0100011, 3'b010, 0);
        step("arst_fetch", 1, 0, ex_fetch(1));
        step("arst_decode", 1, 0, ex_decode());
        step("arst_memadr", 1, 0, ex_memadr());
        step("arst_memwrite", 0, 0, ex_memwrite());
        bus.mem_ready = 1'b0;
        #2;
        check_vec("arst_before", snap(), ex_memwrite());
        rst = 1'b1;
        #1;
        check_vec("arst_after", snap(), ex_fetch(0));
        check_vec("arst_mem_write", {17'b0, bus.mem_write}, 18'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // illegal opcode
        set_ir(7'b1111111, 3'b000, 0);
        step("ill_op_fetch", 1, 0, ex_fetch(1));
        step("ill_op_decode", 1, 0, ex_decode());
`ifdef ILLEGAL_TRAP_EN
        step("ill_op_fault", 1, 0, ex_fault(2'b10));
        step("ill_op_sticky", 1, 0, ex_fault(2'b10));
        do_reset();
`endif
        // illegal funct3 on R-type
        set_ir(R_OP, 3'b001, 0);
        step("ill_f3_fetch", 1, 0, ex_fetch(1));
        step("ill_f3_decode", 1, 0, ex_decode());
        step("ill_f3_exec", 1, 0, ex_exec(3'b000, 0));
`ifdef ILLEGAL_TRAP_EN
        step("ill_f3_fault", 1, 0, ex_fault(2'b10));
        do_reset();
`endif
        run_alu("post", R_OP, 3'b111, 0, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
